key_press_onehot: RTL

Debounces eight raw push-button inputs and turns each debounced press into a single-hot request word for the downstream 8-to-3 encoder. Presses are queued in a pending register, served lowest-index-first, and handed over one at a time on a valid/ready handshake. It sits between the board-level key pins and the encoder's eight one-hot inputs.

---
 rtl/key_press_onehot.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/key_press_onehot.sv
// rtl/key_press_onehot.sv - debounced key presses queued and served lowest-first as one-hot valid/ready requests
// Defining KPO_DROP_CNT_EN adds the saturating drop_cnt port counting cycles with lost presses.
module key_press_onehot #(
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_in,
   input  logic       ready,
   output logic [7:0] onehot_out,
   output logic       valid
`ifdef KPO_DROP_CNT_EN
   ,
   output logic [7:0] drop_cnt
`endif
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   logic [7:0]       r_sync1;
   logic [7:0]       r_sync2;
   logic [7:0]       r_stable;
   logic [7:0]       r_stable_d;
   logic [DEB_W-1:0] r_cnt [8];
   logic [7:0]       r_pending;
   logic [7:0]       r_onehot;
   logic             r_valid;
   state_t           r_state;

   logic [7:0]       w_press;
   logic [7:0]       w_lowest;
   logic             w_load;
   logic [7:0]       w_load_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   // Stable level only follows sync2 after DEB_CYCLES consecutive disagreeing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable   <= '0;
         r_stable_d <= '0;
         for (int i = 0; i < 8; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_stable_d <= r_stable;
         for (int i = 0; i < 8; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_press     = r_stable & ~r_stable_d;
   assign w_lowest    = r_pending & (~r_pending + 8'd1);
   assign w_load      = (r_state == ST_EMPTY) || ready;
   assign w_load_mask = w_load ? w_lowest : 8'h00;

   // A press on the bit being loaded this cycle re-arms it, so set wins over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_load_mask) | w_press;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_EMPTY;
         r_onehot <= '0;
         r_valid  <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (r_pending != 8'h00) begin
                  r_onehot <= w_lowest;
                  r_valid  <= 1'b1;
                  r_state  <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (ready) begin
                  if (r_pending != 8'h00) begin
                     r_onehot <= w_lowest;
                  end else begin
                     r_onehot <= '0;
                     r_valid  <= 1'b0;
                     r_state  <= ST_EMPTY;
                  end
               end
            end
            default: begin
               r_onehot <= '0;
               r_valid  <= 1'b0;
               r_state  <= ST_EMPTY;
            end
         endcase
      end
   end

   assign onehot_out = r_onehot;
   assign valid      = r_valid;

`ifdef KPO_DROP_CNT_EN
   logic [7:0] r_drop_cnt;
   logic [7:0] w_lost;

   assign w_lost = w_press & r_pending & ~w_load_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if ((w_lost != 8'h00) && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule
